// File: rtl/wb_write_arbiter.sv
// Register-file write-port master: merges the non-stalling pipeline writeback
// with a buffered long-latency result stream and tracks pending destinations.
module wb_write_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_we,
    input  logic [4:0]   pipe_rd,
    input  logic [N-1:0] pipe_data,
    input  logic         lu_issue,
    input  logic [4:0]   lu_issue_rd,
    input  logic         lu_valid,
    input  logic [4:0]   lu_rd,
    input  logic [N-1:0] lu_data,
    output logic         lu_ready,
    input  logic [4:0]   src1,
    input  logic [4:0]   src2,
    output logic         hazard,
    output logic         RegWrite,
    output logic [4:0]   rd,
    output logic [N-1:0] write_data,
    output logic [31:0]  busy
);

    logic         buf_v_q, buf_v_d;
    logic [4:0]   buf_rd_q, buf_rd_d;
    logic [N-1:0] buf_data_q, buf_data_d;
    logic         we_q, we_d;
    logic [4:0]   rd_q, rd_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [31:0]  busy_q, busy_d;

    logic pipe_wr;
    logic accept;
    logic drain;

    // Handshake and arbitration: the pipeline always wins the port.
    always_comb begin
        pipe_wr  = pipe_we && (pipe_rd != 5'd0);
        lu_ready = !buf_v_q || !pipe_wr;
        accept   = lu_valid && lu_ready;
        drain    = buf_v_q && !pipe_wr;
        hazard   = ((src1 != 5'd0) && busy_q[src1]) ||
                   ((src2 != 5'd0) && busy_q[src2]);
    end

    // Next write-port value: pipeline first, then buffered result, else idle.
    always_comb begin
        we_d    = 1'b0;
        rd_d    = 5'd0;
        wdata_d = '0;
        if (pipe_wr) begin
            we_d    = 1'b1;
            rd_d    = pipe_rd;
            wdata_d = pipe_data;
        end else if (buf_v_q) begin
            we_d    = 1'b1;
            rd_d    = buf_rd_q;
            wdata_d = buf_data_q;
        end
    end

    // One-entry buffer; an x0 result is accepted but never marked valid.
    always_comb begin
        buf_v_d    = buf_v_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        if (accept) begin
            buf_v_d    = (lu_rd != 5'd0);
            buf_rd_d   = lu_rd;
            buf_data_d = lu_data;
        end else if (drain) begin
            buf_v_d = 1'b0;
        end
    end

    // Scoreboard: clear on drain, then set on issue so a reissue wins.
    always_comb begin
        busy_d = busy_q;
        if (drain)
            busy_d[buf_rd_q] = 1'b0;
        if (lu_issue && (lu_issue_rd != 5'd0))
            busy_d[lu_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_v_q    <= 1'b0;
            buf_rd_q   <= 5'd0;
            buf_data_q <= '0;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
            wdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            buf_v_q    <= buf_v_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite   = we_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-based reference model
// predicts each write-port cycle; a monitor compares after every edge.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        lu_issue = 1'b0;
    logic [4:0]  lu_issue_rd = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic [4:0]  src1 = '0;
    logic [4:0]  src2 = '0;
    logic        hazard;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] busy;

    wb_write_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready),
        .src1(src1), .src2(src2), .hazard(hazard),
        .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] busy;
    } exp_t;

    // Reference model: pending long-latency results and outstanding regs.
    res_t lq[$];
    bit   mb[32];
    exp_t expq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req,
                     $time);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = mb[i];
        return v;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model.
    task automatic cycle(input bit pwe, input logic [4:0] prd,
                         input logic [31:0] pd, input bit iss,
                         input logic [4:0] ird, input bit lv,
                         input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] s1, input logic [4:0] s2);
        bit   pwr, rdy, hz;
        exp_t e;
        res_t r;
        @(negedge clk);
        pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        lu_issue = iss; lu_issue_rd = ird;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        src1 = s1; src2 = s2;
        #1;
        pwr = pwe && (prd != 0);
        rdy = (lq.size() == 0) || !pwr;
        hz  = (s1 != 0 && mb[s1]) || (s2 != 0 && mb[s2]);
        chk("lu_ready", {31'd0, lu_ready}, {31'd0, rdy});
        chk("hazard", {31'd0, hazard}, {31'd0, hz});
        e.we = 1'b0; e.rd = '0; e.data = '0;
        if (pwr) begin
            e.we = 1'b1; e.rd = prd; e.data = pd;
        end else if (lq.size() > 0) begin
            r = lq.pop_front();
            e.we = 1'b1; e.rd = r.rd; e.data = r.data;
            mb[r.rd] = 1'b0;
        end
        if (lv && rdy && lrd != 0) begin
            r.rd = lrd; r.data = ld;
            lq.push_back(r);
        end
        if (iss && ird != 0) mb[ird] = 1'b1;
        e.busy = busy_vec();
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
        chk({tag, "_rd"}, {27'd0, rd}, 32'd0);
        chk({tag, "_wdata"}, write_data, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_ready"}, {31'd0, lu_ready}, 32'd1);
        chk({tag, "_hazard"}, {31'd0, hazard}, 32'd0);
    endtask

    // Monitor: compare registered outputs just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
                chk("rd", {27'd0, rd}, {27'd0, e.rd});
                chk("write_data", write_data, e.data);
                chk("busy", busy, e.busy);
            end
        end
    end

    initial begin
        bit pwe, iss, lv;
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        src1 = 5'd5;
        src2 = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        check_reset("init");
        @(negedge clk);
        rst = 1'b0;

        // Pipeline only, then pipe_rd = 0 suppressed.
        cycle(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'h5678, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Long-latency path with hazard on src1 = 7.
        cycle(0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        cycle(0, 0, 0, 0, 0, 1, 7, 32'hDEAD, 7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

        // Contention: rd=9 held while pipeline writes for 3 cycles.
        cycle(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 10, 1, 9, 32'h9999, 9, 0);
        cycle(1, 1, 32'h11, 0, 0, 1, 10, 32'hA0A0, 9, 10);
        cycle(1, 2, 32'h22, 0, 0, 1, 10, 32'hA0A0, 9, 10);
        cycle(1, 3, 32'h33, 0, 0, 1, 10, 32'hA0A0, 9, 10);
        cycle(0, 0, 0, 0, 0, 1, 10, 32'hA0A0, 9, 10);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
        idle(1);

        // Drain rd=4 on the same edge it is reissued.
        cycle(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 4, 32'h4444, 4, 0);
        cycle(0, 0, 0, 1, 4, 0, 0, 0, 4, 0);
        cycle(0, 0, 0, 0, 0, 1, 4, 32'h4445, 4, 0);
        idle(2);

        // x0 handling.
        cycle(0, 0, 0, 1, 0, 1, 0, 32'hFFFF, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Reset with a buffered rd=5 result still pending.
        cycle(0, 0, 0, 1, 5, 0, 0, 0, 5, 0);
        cycle(0, 0, 0, 0, 0, 1, 5, 32'hAAAA5555, 5, 0);
        cycle(1, 1, 32'h77, 0, 0, 0, 0, 0, 5, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        lq.delete();
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Randomized traffic on a small register range to force overlap.
        for (int i = 0; i < 600; i++) begin
            pwe = ($urandom_range(0, 9) < 5);
            iss = ($urandom_range(0, 9) < 3);
            lv  = ($urandom_range(0, 9) < 4);
            cycle(pwe, 5'($urandom_range(0, 7)), $urandom,
                  iss, 5'($urandom_range(0, 7)),
                  lv, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(4);

        repeat (4) @(posedge clk);
        #2;
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback-side write-port master for the register file. It merges two result sources onto the file's single write port (RegWrite/rd/write_data): the in-order pipeline writeback, which can never stall, and a long-latency unit (mul/div/load-miss), which uses a valid/ready handshake. A one-entry buffer holds long-latency results. A 32-bit scoreboard tracks destinations with outstanding long-latency writes, and a combinational hazard flag is produced for decode.

## Interface
Parameters:
- N, 32, data width of write_data, pipe_data and lu_data.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request. Always accepted; there is no ready.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  N  pipeline result.
- lu_issue  in  1  long-latency op issued this cycle.
- lu_issue_rd  in  5  destination of the issued op.
- lu_valid  in  1  long-latency result valid.
- lu_rd  in  5  long-latency result destination.
- lu_data  in  N  long-latency result data.
- lu_ready  out  1  combinational; the result is accepted at the edge where lu_valid && lu_ready.
- src1, src2  in  5  decode-stage source registers.
- hazard  out  1  combinational; a source is awaiting a long-latency write.
- RegWrite  out  1  registered; write enable to the register file.
- rd  out  5  registered; write address.
- write_data  out  N  registered; write data.
- busy  out  32  registered scoreboard bitmap.

## Operation
Effective pipeline write:
- pipe_wr = pipe_we && pipe_rd != 0.

Buffer:
- State: buf_v, buf_rd, buf_data.
- lu_ready = !buf_v || !pipe_wr, i.e. the buffer is empty or drains this cycle.
- Accept (lu_valid && lu_ready) loads buf_rd/buf_data and sets buf_v.
- A result with lu_rd == 0 is accepted and then discarded: buf_v is not set.

Output select, evaluated each posedge, priority order:
- pipe_wr: RegWrite=1, rd=pipe_rd, write_data=pipe_data. The buffer holds.
- Else if buf_v: RegWrite=1, rd=buf_rd, write_data=buf_data. buf_v clears unless a new accept reloads it in the same edge.
- Else: RegWrite=0, rd=0, write_data=0.

Buffer ordering:
- Drain and accept in the same edge: the old entry goes out and the new entry is loaded.
- A result is never written to the port in the same cycle it is accepted.

Scoreboard:
- Set: busy[lu_issue_rd] is set at an edge with lu_issue && lu_issue_rd != 0.
- Clear: busy[buf_rd] is cleared at the edge where the buffer entry is driven to the output.
- Same register set and cleared at one edge: set wins.
- busy[0] is constant 0.

Hazard:
- hazard = (src1 != 0 && busy[src1]) || (src2 != 0 && busy[src2]).
- It uses the registered busy value only.

WAW and protocol errors:
- A pipeline write to a busy register is still performed, and busy is unchanged. The later long-latency result overwrites it.
- A long-latency result for a non-busy register is written normally.

## Timing
Reset:
- rst asserted at any time immediately forces RegWrite=0, rd=0, write_data=0, busy=0 and buf_v=0.
- As a result lu_ready=1 and hazard=0.
- A buffered result is lost on reset mid-operation.

Pipeline path latency:
- pipe_we sampled at edge k gives RegWrite high during cycle k..k+1.
- The register file captures the write at the following negedge.

Long-latency path latency:
- Accepted at edge k, written at the first edge > k with no pipe_wr.
- Minimum latency is one cycle more than the pipeline path.

Backpressure:
- lu_ready deasserts only when buf_v && pipe_wr.
- Back-to-back pipeline writes starve the buffer indefinitely. This is by design: the pipeline has priority.

Scoreboard and hazard timing:
- The busy bit clears on the same edge RegWrite rises for that result.
- hazard therefore drops that cycle, and decode reads the new value after the negedge write.
- Throughput: one register-file write per cycle maximum.

## Test plan
- Reset mid-operation: lu_issue rd=5, then accept lu result rd=5 data 0xAAAA_5555, assert rst before drain -> RegWrite=0, busy=0, lu_ready=1, no write to x5 ever occurs.
- Pipeline only: pipe_we rd=3 data 0x1234 at edge k -> RegWrite=1, rd=3, write_data=0x1234 in cycle k; pipe_rd=0 -> RegWrite=0.
- Long-latency path: issue rd=7 (busy[7]=1, hazard for src1=7), result 0xDEAD accepted at edge k, no pipe traffic -> RegWrite=1, rd=7, write_data=0xDEAD at edge k+1, busy[7]=0, hazard=0.
- Contention: buffer holds rd=9 while pipe_we is active for 3 cycles with lu_valid high -> lu_ready=0 for those 3 cycles, pipeline writes are emitted in order, then rd=9 drains in cycle 4.
- Simultaneous drain and reissue: drain rd=4 at the same edge as lu_issue rd=4 -> busy[4] remains 1; drain and accept at the same edge -> the old entry is written and the new entry is written the next cycle.
- x0 handling: lu_issue rd=0 and a result rd=0 -> busy stays 0 and no RegWrite pulse; src1=0 never raises hazard.
